// File: rtl/vga_pkg.sv
// Shared constants and types for the camera-to-VGA display path.
// Holds the 640x480@60 timing (active, porches, sync), the stored camera
// frame geometry (174x144), the "outside window" address code, and the
// RGB565 pixel layout together with its 8-bit-per-channel expansion helpers.
package vga_pkg;

  // Horizontal timing, in pixel clocks.
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_END   = HS_START + H_SYNC;

  // Vertical timing, in lines.
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] VS_START = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_END   = VS_START + V_SYNC;

  // Stored camera frame geometry.
  localparam logic [9:0] CAM_W = 10'd174;
  localparam logic [9:0] CAM_H = 10'd144;

  // Address driven to the buffer when the beam is outside the window.
  localparam logic [9:0] ADDR_NONE = 10'h3FF;

  // Control bits travelling alongside the buffer read latency.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
  } vga_ctrl_t;

  // Idle control word: syncs inactive (high), no video, outside window.
  localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0};

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Widen a colour channel by replicating its MSBs into the new LSBs so
  // full-scale input maps to full-scale output.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator.
// Ports:
//   rd_clk      - pixel clock (25 MHz)
//   reset       - asynchronous active-low reset
//   h_nxt/v_nxt - counter values that will be loaded on the next edge,
//                 so that downstream registered logic stays aligned with h/v
//   hs_raw      - horizontal sync for the current counter state, active-low
//   vs_raw      - vertical sync for the current counter state, active-low
//   de_raw      - active-video flag for the current counter state
//   frame_done  - registered one-cycle pulse while the counters sit at
//                 (h=0, v=480), i.e. the first cycle of vertical blanking
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic       rd_clk,
  input  logic       reset,
  output logic [9:0] h_nxt,
  output logic [9:0] v_nxt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       de_raw,
  output logic       frame_done
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       frame_done_q, frame_done_d;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it holding a value and no latch is inferred.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_TOTAL - 10'd1) begin
      h_d = 10'd0;
      v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
    end
    // Registered so it rises on the same edge that lands on (0, 480).
    frame_done_d = (h_d == 10'd0) && (v_d == V_ACTIVE);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      frame_done_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign h_nxt      = h_d;
  assign v_nxt      = v_d;
  assign hs_raw     = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw     = !((v_q >= VS_START) && (v_q < VS_END));
  assign de_raw     = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
  assign frame_done = frame_done_q;

endmodule

// File: rtl/cam_vga_reader.sv
// Display-side reader of the camera frame buffer.
// Generates 640x480@60 timing, addresses the buffer so the 174x144 frame is
// upscaled by SCALE into a window starting at (WIN_X0, WIN_Y0), and delays
// sync/enable by MEM_LAT+1 cycles so they line up with the returned pixels.
// Ports:
//   rd_clk          - pixel clock, also clocks the buffer read port
//   reset           - asynchronous active-low reset
//   x_addr/y_addr   - buffer column/row, ADDR_NONE outside the window
//   value           - RGB565 pixel from the buffer, MEM_LAT edges after address
//   frame_done      - one-cycle pulse at the start of vertical blanking
//   vga_hs/vga_vs   - active-low syncs, aligned with the pixel outputs
//   vga_de          - active-video flag, aligned with the pixel outputs
//   vga_r/g/b       - 8-bit colour, black outside the window or blanking
module cam_vga_reader
  import vga_pkg::*;
#(
  parameter int SCALE   = 3,
  parameter int WIN_X0  = 59,
  parameter int WIN_Y0  = 24,
  parameter int MEM_LAT = 2
) (
  input  logic        rd_clk,
  input  logic        reset,
  output logic [9:0]  x_addr,
  output logic [9:0]  y_addr,
  input  logic [15:0] value,
  output logic        frame_done,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
  localparam logic [9:0] WX0 = 10'(WIN_X0);
  localparam logic [9:0] WX1 = 10'(WIN_X0 + int'(CAM_W) * SCALE);
  localparam logic [9:0] WY0 = 10'(WIN_Y0);
  localparam logic [9:0] WY1 = 10'(WIN_Y0 + int'(CAM_H) * SCALE);

  // ---------------------------------------------------------------------
  // Raster timing
  // ---------------------------------------------------------------------
  logic [9:0] h_nxt, v_nxt;
  logic       hs_raw, vs_raw, de_raw;

  vga_timing_gen u_timing (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .h_nxt      (h_nxt),
    .v_nxt      (v_nxt),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .de_raw     (de_raw),
    .frame_done (frame_done)
  );

  // ---------------------------------------------------------------------
  // Window address generator. Decisions are taken on the counter values
  // about to be loaded, so the registered addresses change on the same
  // edge as h/v. Scaling uses sub-counters instead of a divider.
  // ---------------------------------------------------------------------
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [9:0]    xc_q, xc_d, yc_q, yc_d;
  logic [9:0]    x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic          col_in, row_in, line_wrap;

  always_comb begin
    col_in    = (h_nxt >= WX0) && (h_nxt < WX1);
    row_in    = (v_nxt >= WY0) && (v_nxt < WY1);
    line_wrap = (h_nxt == 10'd0);

    sx_d = sx_q;
    xc_d = xc_q;
    if (h_nxt == WX0) begin
      sx_d = '0;
      xc_d = 10'd0;
    end else if (col_in) begin
      if (sx_q == S_LAST) begin
        sx_d = '0;
        xc_d = xc_q + 10'd1;
      end else begin
        sx_d = sx_q + SW'(1);
      end
    end

    // Rows advance once per line, on the edge that wraps h to 0.
    sy_d = sy_q;
    yc_d = yc_q;
    if (line_wrap) begin
      if (v_nxt == WY0) begin
        sy_d = '0;
        yc_d = 10'd0;
      end else if (row_in) begin
        if (sy_q == S_LAST) begin
          sy_d = '0;
          yc_d = yc_q + 10'd1;
        end else begin
          sy_d = sy_q + SW'(1);
        end
      end
    end

    x_addr_d = (col_in && row_in) ? xc_d : ADDR_NONE;
    y_addr_d = (col_in && row_in) ? yc_d : ADDR_NONE;
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      sx_q     <= '0;
      sy_q     <= '0;
      xc_q     <= 10'd0;
      yc_q     <= 10'd0;
      x_addr_q <= ADDR_NONE;
      y_addr_q <= ADDR_NONE;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
    end
  end

  assign x_addr = x_addr_q;
  assign y_addr = y_addr_q;

  // ---------------------------------------------------------------------
  // Control delay line: MEM_LAT stages track the buffer latency, and the
  // output register adds the final cycle in which the pixel is captured.
  // ---------------------------------------------------------------------
  vga_ctrl_t [MEM_LAT-1:0] ctrl_pipe_q, ctrl_pipe_d;
  vga_ctrl_t               tail;
  rgb565_t                 px;
  logic                    vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic                    vga_de_q, vga_de_d;
  logic [7:0]              vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;

  always_comb begin
    ctrl_pipe_d[0] = '{hs: hs_raw, vs: vs_raw, de: de_raw,
                       win: (x_addr_q != ADDR_NONE)};
    for (int i = 1; i < MEM_LAT; i++) begin
      ctrl_pipe_d[i] = ctrl_pipe_q[i-1];
    end

    tail     = ctrl_pipe_q[MEM_LAT-1];
    px       = rgb565_t'(value);
    vga_hs_d = tail.hs;
    vga_vs_d = tail.vs;
    vga_de_d = tail.de;
    vga_r_d  = 8'd0;
    vga_g_d  = 8'd0;
    vga_b_d  = 8'd0;
    if (tail.de && tail.win) begin
      vga_r_d = expand5(px.r);
      vga_g_d = expand6(px.g);
      vga_b_d = expand5(px.b);
    end
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      // NOTE: pipeline stages reset to the idle control word (syncs high,
      // no video) rather than all-zero, so no spurious sync pulse leaves
      // the block while the delay line refills after reset.
      ctrl_pipe_q <= {MEM_LAT{CTRL_IDLE}};
      vga_hs_q    <= 1'b1;
      vga_vs_q    <= 1'b1;
      vga_de_q    <= 1'b0;
      vga_r_q     <= 8'd0;
      vga_g_q     <= 8'd0;
      vga_b_q     <= 8'd0;
    end else begin
      ctrl_pipe_q <= ctrl_pipe_d;
      vga_hs_q    <= vga_hs_d;
      vga_vs_q    <= vga_vs_d;
      vga_de_q    <= vga_de_d;
      vga_r_q     <= vga_r_d;
      vga_g_q     <= vga_g_d;
      vga_b_q     <= vga_b_d;
    end
  end

  assign vga_hs = vga_hs_q;
  assign vga_vs = vga_vs_q;
  assign vga_de = vga_de_q;
  assign vga_r  = vga_r_q;
  assign vga_g  = vga_g_q;
  assign vga_b  = vga_b_q;

endmodule

// File: tb/tb_cam_vga_reader.sv
// Self-checking bench for cam_vga_reader. A random camera frame sits in a
// two-cycle-latency buffer model; the expected raster, addresses and pixels
// are computed from the cycle count since reset release with plain
// arithmetic (h = n mod 800, v = n div 800, address = offset div SCALE).
module tb_cam_vga_reader;

  localparam int LAT      = 3;        // buffer latency + output register
  localparam int MAX_FAIL = 25;

  logic        rd_clk = 1'b0;
  logic        reset  = 1'b0;
  logic [9:0]  x_addr, y_addr;
  logic [15:0] value  = 16'h0;
  logic [15:0] mem_s1 = 16'h0;
  logic        frame_done, vga_hs, vga_vs, vga_de;
  logic [7:0]  vga_r, vga_g, vga_b;

  always #20 rd_clk = ~rd_clk;

  cam_vga_reader #(.SCALE(3), .WIN_X0(59), .WIN_Y0(24), .MEM_LAT(2)) dut (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .x_addr     (x_addr),
    .y_addr     (y_addr),
    .value      (value),
    .frame_done (frame_done),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_de     (vga_de),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
  );

  // Camera frame and buffer read port with two edges of latency.
  logic [15:0] frame [0:174*144-1];

  function automatic logic [15:0] fetch(input logic [9:0] x, input logic [9:0] y);
    if (x < 10'd174 && y < 10'd144) return frame[int'(y) * 174 + int'(x)];
    return 16'h0;
  endfunction

  always @(posedge rd_clk) begin
    mem_s1 <= fetch(x_addr, y_addr);
    value  <= mem_s1;
  end

  // Bookkeeping.
  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;      // clock edges since reset release
  bit abort    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, n, got, exp);
      if (n_checks - n_pass >= MAX_FAIL) abort = 1'b1;
    end
  endtask

  // Reference model helpers.
  function automatic bit in_window(input int h, input int v);
    return h >= 59 && h < 59 + 174*3 && v >= 24 && v < 24 + 144*3;
  endfunction

  function automatic logic [26:0] expected_video(input int k);
    int h, v;
    logic ehs, evs, ede;
    logic [15:0] px;
    if (k < LAT) return {1'b1, 1'b1, 1'b0, 24'h0};
    h   = (k - LAT) % 800;
    v   = ((k - LAT) / 800) % 525;
    ehs = !(h >= 656 && h <= 751);
    evs = !(v >= 490 && v <= 491);
    ede = h < 640 && v < 480;
    px  = (ede && in_window(h, v)) ? frame[((v - 24) / 3) * 174 + (h - 59) / 3] : 16'h0;
    return {ehs, evs, ede, px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

  // Pulse-width trackers on the output side.
  int   hs_low_run, de_high_run, vs_low_run, de_lines, vs_pulses, fd_count, fd_cycle, first_fall;
  logic prev_hs;

  task automatic clear_trackers();
    hs_low_run = 0; de_high_run = 0; vs_low_run = 0; de_lines = 0;
    vs_pulses = 0; fd_count = 0; fd_cycle = -1; first_fall = -1; prev_hs = 1'b1;
  endtask

  task automatic sample();
    int h, v;
    logic [9:0] ex, ey;
    h  = n % 800;
    v  = (n / 800) % 525;
    ex = in_window(h, v) ? 10'((h - 59) / 3) : 10'h3FF;
    ey = in_window(h, v) ? 10'((v - 24) / 3) : 10'h3FF;
    check("x_addr", 32'(x_addr), 32'(ex));
    check("y_addr", 32'(y_addr), 32'(ey));
    check("frame_done", 32'(frame_done), 32'(h == 0 && v == 480));
    check("video{hs,vs,de,rgb}", 32'({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}),
          32'(expected_video(n)));

    if (v == 24 && h == 24'd62 - 0) check("latency_red", 32'({vga_r, vga_g, vga_b}), 32'h00FF0000);
    if (v == 24 && h == 61)         check("latency_black", 32'({vga_r, vga_g, vga_b}), 32'h0);

    if (prev_hs && !vga_hs && first_fall < 0) begin
      first_fall = n;
      check("first_hs_fall", 32'(n), 32'(656 + LAT));
    end
    prev_hs = vga_hs;

    if (!vga_hs) hs_low_run++;
    else begin
      if (hs_low_run != 0) check("hs_width", 32'(hs_low_run), 32'd96);
      hs_low_run = 0;
    end

    if (vga_de) de_high_run++;
    else begin
      if (de_high_run != 0) begin
        check("de_width", 32'(de_high_run), 32'd640);
        de_lines++;
      end
      de_high_run = 0;
    end

    if (!vga_vs) vs_low_run++;
    else begin
      if (vs_low_run != 0) begin
        check("vs_width", 32'(vs_low_run), 32'd1600);
        vs_pulses++;
      end
      vs_low_run = 0;
    end

    if (frame_done) begin
      fd_count++;
      if (fd_cycle < 0) fd_cycle = n;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_addr"}, 32'(x_addr), 32'h3FF);
    check({tag, "_y_addr"}, 32'(y_addr), 32'h3FF);
    check({tag, "_syncs_de"}, 32'({vga_hs, vga_vs, vga_de}), 32'b110);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Run with the model checking every cycle until n reaches last.
  task automatic run_until(input int last);
    while (n < last && !abort) begin
      @(negedge rd_clk);
      n++;
      sample();
    end
  endtask

  initial begin
    for (int i = 0; i < 174*144; i++) frame[i] = 16'($urandom);
    frame[0] = 16'hF800;
    clear_trackers();

    // Power-on reset held for 10 cycles.
    reset = 1'b0;
    repeat (10) @(negedge rd_clk);
    check_reset_outputs("reset");

    // First frame, through the top of the window and into its rows.
    reset = 1'b1;
    n = 0;
    sample();
    run_until(35*800 + 300);

    // Mid-frame reset inside the window: outputs must drop without a clock.
    if (!abort) begin
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (3) @(negedge rd_clk);
      check_reset_outputs("held_reset");

      reset = 1'b1;
      n = 0;
      clear_trackers();
      sample();
      // Through the first frame_done and past the vertical sync pulse.
      run_until(492*800 + 100);

      check("frame_done_cycle", 32'(fd_cycle), 32'(480*800));
      check("frame_done_pulses", 32'(fd_count), 32'd1);
      check("de_lines", 32'(de_lines), 32'd480);
      check("vs_pulses", 32'(vs_pulses), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
